// File: rtl/rrg_param_loader.sv
// rrg_param_loader: serialises one 4-parameter ramp job onto the reg_control/reg_0..3 word bus
// Ports: clk_slow/nReset (sync, active-low); s_valid/s_ready job handshake with s_yset,
// s_rset, s_riset, s_roset (64-bit); reg_control code (0 idle, 1-4 stage, 5 commit) with
// reg_3..reg_0 data; done pulse on commit completion; busy; commit_count (wrapping).
// Option: RRG_LOADER_SKIP_UNCHANGED_EN skips staging words equal to the last committed job.
module rrg_param_loader #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clk_slow,
  input  logic        nReset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_yset,
  input  logic [63:0] s_rset,
  input  logic [63:0] s_riset,
  input  logic [63:0] s_roset,
  output logic [15:0] reg_control,
  output logic [15:0] reg_3,
  output logic [15:0] reg_2,
  output logic [15:0] reg_1,
  output logic [15:0] reg_0,
  output logic        done,
  output logic        busy,
  output logic [15:0] commit_count
);
  typedef enum logic [1:0] {IDLE, STAGE, COMMIT, GAP} state_t;
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  state_t      r_state, w_state_nx;
  logic [2:0]  r_idx, w_idx_nx, w_nidx, w_cur;
  logic [1:0]  w_sel;
  logic [7:0]  r_hold, w_hold_nx;
  logic [63:0] r_job [4];
  logic [63:0] w_src [4];
  logic [63:0] w_data_nx;
  logic [3:0]  w_wr;
  logic        w_accept;
`ifdef RRG_LOADER_SKIP_UNCHANGED_EN
  logic [63:0] r_last [4];
  logic        r_last_ok;
`endif
  assign s_ready = r_state == IDLE;
  assign busy    = r_state != IDLE;
  // In IDLE the words come straight from the inputs so the first phase can be driven on the accept edge
  assign w_src[0] = s_ready ? s_yset  : r_job[0];
  assign w_src[1] = s_ready ? s_rset  : r_job[1];
  assign w_src[2] = s_ready ? s_riset : r_job[2];
  assign w_src[3] = s_ready ? s_roset : r_job[3];
  assign w_cur    = s_ready ? 3'd0 : r_idx;
`ifdef RRG_LOADER_SKIP_UNCHANGED_EN
  always_comb begin
    w_wr = 4'hF;
    for (int k = 0; k < 4; k++) w_wr[k] = !(r_last_ok && w_src[k] == r_last[k]);
  end
`else
  assign w_wr = 4'hF;
`endif
  always_comb begin
    w_nidx = 3'd5;
    for (int k = 3; k >= 0; k--) if (k >= int'(w_cur) && w_wr[k]) w_nidx = 3'(k + 1);
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_hold_nx  = r_hold - 8'd1;
    w_accept   = 1'b0;
    if (r_state == IDLE) begin
      w_hold_nx = HOLD_LOAD;
      if (s_valid) begin
        w_accept   = 1'b1;
        w_idx_nx   = w_nidx;
        w_state_nx = w_nidx == 3'd5 ? COMMIT : STAGE;
      end
    end else if (r_state == GAP) begin
      w_state_nx = IDLE;
    end else if (r_hold == 8'd0) begin
      w_hold_nx  = HOLD_LOAD;
      w_idx_nx   = w_nidx;
      w_state_nx = r_state == COMMIT ? GAP : (w_nidx == 3'd5 ? COMMIT : STAGE);
    end
    // index 1..4 maps to word 0..3; index 4 wraps through 0 to 3
    w_sel     = w_idx_nx[1:0] - 2'd1;
    w_data_nx = w_state_nx == STAGE ? w_src[w_sel] : 64'd0;
  end
  always_ff @(posedge clk_slow) begin
    if (!nReset) begin
      r_state      <= IDLE;
      r_idx        <= 3'd0;
      r_hold       <= 8'd0;
      reg_control  <= 16'd0;
      {reg_3, reg_2, reg_1, reg_0} <= 64'd0;
      done         <= 1'b0;
      commit_count <= 16'd0;
    end else begin
      r_state     <= w_state_nx;
      r_idx       <= w_idx_nx;
      r_hold      <= w_hold_nx;
      reg_control <= w_state_nx == STAGE ? {13'd0, w_idx_nx} : (w_state_nx == COMMIT ? 16'd5 : 16'd0);
      {reg_3, reg_2, reg_1, reg_0} <= w_data_nx;
      done        <= w_state_nx == GAP;
      if (r_state == GAP) commit_count <= commit_count + 16'd1;
    end
  end
  always_ff @(posedge clk_slow) begin
    if (w_accept) begin
      r_job[0] <= s_yset;
      r_job[1] <= s_rset;
      r_job[2] <= s_riset;
      r_job[3] <= s_roset;
    end
  end
`ifdef RRG_LOADER_SKIP_UNCHANGED_EN
  always_ff @(posedge clk_slow) begin
    if (!nReset) begin
      r_last_ok <= 1'b0;
      for (int k = 0; k < 4; k++) r_last[k] <= 64'd0;
    end else if (r_state == COMMIT && w_state_nx == GAP) begin
      r_last_ok <= 1'b1;
      for (int k = 0; k < 4; k++) r_last[k] <= r_job[k];
    end
  end
`endif
endmodule
